i2s_tx_scheduler: RTL and testbench

I2S_TX_SCHEDULER -- requirements
Module: i2s_tx_scheduler

---
 rtl/i2s_tx_scheduler.sv | 134 +++++++++++++
 tb/tb_i2s_tx_scheduler.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_tx_scheduler.sv
// Stereo 16-bit I2S transmitter: fractional BCK from a phase accumulator, 32-slot frame, one-pair buffer.
// Define I2S_UNDERRUN_CNT_EN to build the saturating underrun counter; otherwise underrun_count is tied to 0.
module i2s_tx_scheduler #(
  parameter int unsigned CLK_HZ = 6000000,
  parameter int unsigned BCK_HZ = 1411200
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        sample_valid,
  output logic        sample_ready,
  input  logic [15:0] sample_left,
  input  logic [15:0] sample_right,
  output logic        i2s_bck,
  output logic        i2s_lrck,
  output logic        i2s_din,
  output logic        frame_strobe,
  output logic [7:0]  underrun_count
);

  localparam int unsigned ACC_W = $clog2(CLK_HZ + 2 * BCK_HZ);
  localparam logic [ACC_W-1:0] INC = ACC_W'(2 * BCK_HZ);
  localparam logic [ACC_W-1:0] LIM = ACC_W'(CLK_HZ);

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_sum;
  logic             tick;
  logic             fe;
  logic [4:0]       slot;
  logic [4:0]       slot_nxt;
  logic             load;
  logic             accept;
  logic             pend_full;
  logic [15:0]      pend_left;
  logic [15:0]      pend_right;
  logic [15:0]      cur_left;
  logic [15:0]      cur_right;
  logic [15:0]      load_left;
  logic [15:0]      load_right;
  logic [15:0]      chan;
  logic [3:0]       bit_k;
  logic             din_nxt;

  assign sample_ready = !pend_full;

  always_comb begin
    // NOTE: every signal assigned here gets a value on every path first, so no latch can be inferred.
    acc_sum    = acc + INC;
    tick       = en && (acc_sum >= LIM);
    fe         = tick && i2s_bck;
    slot_nxt   = slot + 5'd1;
    load       = fe && (slot_nxt == 5'd1);
    accept     = sample_valid && !pend_full;
    load_left  = pend_full ? pend_left  : '0;
    load_right = pend_full ? pend_right : '0;
    // Slot 1 transmits the MSB of the pair being loaded on that same edge.
    chan       = slot_nxt[4] ? cur_right : (load ? load_left : cur_left);
    bit_k      = slot_nxt[3:0];
    din_nxt    = chan[4'(5'd16 - 5'(bit_k))];
    if (bit_k == 4'd0)
      din_nxt = slot_nxt[4] ? cur_left[0] : cur_right[0];
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc          <= '0;
      i2s_bck      <= 1'b0;
      i2s_lrck     <= 1'b0;
      i2s_din      <= 1'b0;
      slot         <= 5'd31;
      frame_strobe <= 1'b0;
    end else if (!en) begin
      acc          <= '0;
      i2s_bck      <= 1'b0;
      i2s_lrck     <= 1'b0;
      i2s_din      <= 1'b0;
      slot         <= 5'd31;
      frame_strobe <= 1'b0;
    end else begin
      acc          <= tick ? acc_sum - LIM : acc_sum;
      frame_strobe <= fe && (slot_nxt == 5'd0);
      if (tick)
        i2s_bck <= ~i2s_bck;
      if (fe) begin
        slot     <= slot_nxt;
        i2s_lrck <= slot_nxt[4];
        i2s_din  <= din_nxt;
      end
    end
  end

  // Handshake keeps running while en=0; only the serial side is held idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_full <= 1'b0;
      cur_left  <= '0;
      cur_right <= '0;
    end else begin
      if (load) begin
        cur_left  <= load_left;
        cur_right <= load_right;
      end
      if (accept)
        pend_full <= 1'b1;
      else if (load)
        pend_full <= 1'b0;
    end
  end

  // NOTE: the pending data registers are not reset; pend_full gates every use of them.
  always_ff @(posedge clk) begin
    if (accept) begin
      pend_left  <= sample_left;
      pend_right <= sample_right;
    end
  end

`ifdef I2S_UNDERRUN_CNT_EN
  logic [7:0] under_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      under_cnt <= '0;
    else if (load && !pend_full && (under_cnt != 8'hFF))
      under_cnt <= under_cnt + 8'd1;
  end

  assign underrun_count = under_cnt;
`else
  assign underrun_count = '0;
`endif

endmodule

// File: tb/tb_i2s_tx_scheduler.sv
// Self-checking bench for i2s_tx_scheduler: frame-level reference model, vector table and corner-case sequences.
module tb_i2s_tx_scheduler;

  localparam longint CLK_HZ     = 6000000;
  localparam longint BCK_HZ     = 1411200;
  localparam longint INC        = 2 * BCK_HZ;
  localparam int     PERIOD_CLK = 41000;
  localparam int     NVEC       = 8;

  typedef struct {
    logic [15:0] left;
    logic [15:0] right;
    logic [31:0] exp_word;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        sample_valid;
  logic        sample_ready;
  logic [15:0] sample_left;
  logic [15:0] sample_right;
  logic        i2s_bck;
  logic        i2s_lrck;
  logic        i2s_din;
  logic        frame_strobe;
  logic [7:0]  underrun_count;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state, written only by the model process.
  logic [4:0]  m_slot = 5'd31;
  logic        m_bck = 1'b0, m_lrck = 1'b0, m_din = 1'b0, m_strobe = 1'b0;
  logic        m_fe = 1'b0, m_load_now = 1'b0;
  logic [15:0] m_cur_l = '0, m_cur_r = '0;
  longint      m_n = 0, m_ticks = 0;
  int          m_under = 0;
  logic [31:0] q[$];
  logic [31:0] cap_q[$];
  logic [31:0] cap_word = '0;

  i2s_tx_scheduler #(.CLK_HZ(6000000), .BCK_HZ(1411200)) dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .sample_valid(sample_valid), .sample_ready(sample_ready),
    .sample_left(sample_left), .sample_right(sample_right),
    .i2s_bck(i2s_bck), .i2s_lrck(i2s_lrck), .i2s_din(i2s_din),
    .frame_strobe(frame_strobe), .underrun_count(underrun_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: timed out (t=%0t)", name, $time);
  endtask

  // Slot s of a frame carrying (l, r); bit 0 is unused here (slot 0 belongs to the previous pair).
  function automatic logic [31:0] frame_word(input logic [15:0] l, input logic [15:0] r);
    logic [31:0] w;
    w = '0;
    for (int s = 1; s < 32; s++)
      w[s] = (s < 16) ? l[16-s] : ((s == 16) ? l[0] : r[32-s]);
    return w;
  endfunction

  // Reference model: tick count = floor(n * 2*BCK / CLK) after n enabled clocks.
  initial begin : model
    logic        xfer, en_s, rst_s;
    logic [31:0] xpair, fw, pr;
    logic [7:0]  exp_u;
    longint      t_new;
    forever begin
      @(negedge clk);
      #1;
      xfer  = sample_valid && sample_ready;
      xpair = {sample_left, sample_right};
      @(posedge clk);
      en_s  = en;
      rst_s = rst_n;
      #1;
      m_fe = 1'b0; m_load_now = 1'b0; m_strobe = 1'b0;
      if (!rst_s) begin
        m_n = 0; m_ticks = 0; m_slot = 5'd31; m_under = 0;
        m_bck = 1'b0; m_lrck = 1'b0; m_din = 1'b0;
        m_cur_l = '0; m_cur_r = '0;
        q.delete();
      end else begin
        if (!en_s) begin
          m_n = 0; m_ticks = 0; m_slot = 5'd31;
          m_bck = 1'b0; m_lrck = 1'b0; m_din = 1'b0;
        end else begin
          m_n++;
          t_new = (m_n * INC) / CLK_HZ;
          if (t_new != m_ticks) begin
            m_fe    = m_bck;
            m_bck   = !m_bck;
            m_ticks = t_new;
          end
          if (m_fe) begin
            m_slot = m_slot + 5'd1;
            if (m_slot == 5'd1) begin
              m_load_now = 1'b1;
              if (q.size() > 0) begin
                pr = q.pop_front();
                m_cur_l = pr[31:16];
                m_cur_r = pr[15:0];
              end else begin
                m_cur_l = '0;
                m_cur_r = '0;
                if (m_under < 255) m_under++;
              end
            end
            fw       = frame_word(m_cur_l, m_cur_r);
            m_din    = (m_slot == 5'd0) ? m_cur_r[0] : fw[m_slot];
            m_lrck   = (m_slot >= 5'd16);
            m_strobe = (m_slot == 5'd0);
            cap_word[m_slot] = i2s_din;
            if (m_slot == 5'd31) cap_q.push_back(cap_word);
          end
        end
        if (xfer) q.push_back(xpair);
      end
`ifdef I2S_UNDERRUN_CNT_EN
      exp_u = 8'(m_under);
`else
      exp_u = 8'd0;
`endif
      check("pins", {19'd0, i2s_bck, i2s_lrck, i2s_din, frame_strobe, sample_ready, underrun_count},
                    {19'd0, m_bck, m_lrck, m_din, m_strobe, (q.size() == 0), exp_u});
    end
  end

  task automatic wait_ready(input string name, input int limit);
    int c = 0;
    while (!sample_ready && c < limit) begin
      @(negedge clk);
      c++;
    end
    if (!sample_ready) timeout_fail(name);
  endtask

  task automatic wait_slot(input logic [4:0] target, input string name);
    int c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (!(m_fe && m_slot == target) && c < 600);
    if (!(m_fe && m_slot == target)) timeout_fail(name);
  endtask

  initial begin : stim
    vec_t   tbl[NVEC];
    int     toggles, strobes, ones, c, bad_pins;
    longint exp_tog, exp_fe, exp_strb, exp_loads;
    logic   prev, early, seen;
    logic [31:0] exp_u;

    tbl[0] = '{16'h8001, 16'h7FFE, 32'hFFFD0002};
    tbl[1] = '{16'hFFFF, 16'h0000, 32'h0001FFFE};
    tbl[2] = '{16'h0000, 16'hFFFF, 32'hFFFE0000};
    tbl[3] = '{16'h0001, 16'h8000, 32'h00030000};
    for (int i = 4; i < NVEC; i++) begin
      tbl[i].left     = 16'($urandom);
      tbl[i].right    = 16'($urandom);
      tbl[i].exp_word = frame_word(tbl[i].left, tbl[i].right);
    end

    rst_n = 1'b1; en = 1'b0; sample_valid = 1'b0; sample_left = '0; sample_right = '0;
    #1 rst_n = 1'b0;
    #1;
    check("reset_pins", {28'd0, i2s_bck, i2s_lrck, i2s_din, frame_strobe}, 32'd0);
    check("reset_ready", {31'd0, sample_ready}, 32'd1);
    check("reset_underrun", {24'd0, underrun_count}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Period and underrun: no samples offered for ~300 frames.
    en = 1'b1;
    toggles = 0; strobes = 0; ones = 0; prev = i2s_bck;
    repeat (PERIOD_CLK) begin
      @(negedge clk);
      if (i2s_bck !== prev) toggles++;
      prev = i2s_bck;
      strobes += int'(frame_strobe);
      ones    += int'(i2s_din);
    end
    exp_tog   = (longint'(PERIOD_CLK) * INC) / CLK_HZ;
    exp_fe    = exp_tog / 2;
    exp_strb  = (exp_fe + 31) / 32;
    exp_loads = (exp_fe >= 2) ? (exp_fe - 2) / 32 + 1 : 0;
`ifdef I2S_UNDERRUN_CNT_EN
    exp_u = (exp_loads > 255) ? 32'd255 : 32'(exp_loads);
`else
    exp_u = 32'd0;
`endif
    check("period_bck_toggles", 32'(toggles), 32'(exp_tog));
    check("period_frame_strobes", 32'(strobes), 32'(exp_strb));
    check("underrun_din_ones", 32'(ones), 32'd0);
    check("underrun_count", {24'd0, underrun_count}, exp_u);

    // Serial format vectors: one pair per frame, captured slots 1..31.
    for (int i = 0; i < NVEC; i++) begin
      wait_ready($sformatf("vec%0d_ready", i), 400);
      sample_left = tbl[i].left; sample_right = tbl[i].right; sample_valid = 1'b1;
      @(negedge clk);
      sample_valid = 1'b0;
      check($sformatf("vec%0d_accept", i), {31'd0, sample_ready}, 32'd0);
      wait_ready($sformatf("vec%0d_load", i), 400);
      cap_q.delete();
      c = 0;
      while (cap_q.size() == 0 && c < 400) begin
        @(negedge clk);
        c++;
      end
      if (cap_q.size() == 0) timeout_fail($sformatf("vec%0d_frame", i));
      else check($sformatf("vec%0d_frame", i), cap_q[0] & 32'hFFFF_FFFE, tbl[i].exp_word & 32'hFFFF_FFFE);
    end

    // Backpressure: valid held with two distinct pairs.
    wait_ready("bp_idle", 400);
    sample_left = 16'h1357; sample_right = 16'h2468; sample_valid = 1'b1;
    @(negedge clk);
    check("bp_first_accept", {31'd0, sample_ready}, 32'd0);
    sample_left = 16'hC0DE; sample_right = 16'h0F0F;
    c = 0;
    while (!sample_ready && c < 400) begin
      @(negedge clk);
      c++;
    end
    if (!sample_ready) timeout_fail("bp_release");
    else check("bp_release_on_load", {31'd0, m_load_now}, 32'd1);
    @(negedge clk);
    check("bp_second_accept", {31'd0, sample_ready}, 32'd0);
    sample_valid = 1'b0;
    wait_ready("bp_second_load", 400);

    // Disable at slot 9 for 50 clocks.
    wait_slot(5'd9, "dis_slot9");
    en = 1'b0;
    bad_pins = 0;
    repeat (50) begin
      @(negedge clk);
      if (i2s_bck || i2s_lrck || i2s_din) bad_pins++;
    end
    check("dis_pins_low", 32'(bad_pins), 32'd0);
    en = 1'b1;
    early = 1'b0; seen = 1'b0; c = 0;
    while (!seen && c < 400) begin
      @(negedge clk);
      c++;
      if (frame_strobe) seen = 1'b1;
      else if (i2s_din) early = 1'b1;
    end
    if (!seen) timeout_fail("dis_first_strobe");
    else begin
      check("dis_no_din_before_strobe", {31'd0, early}, 32'd0);
      check("dis_slot0_din", {31'd0, i2s_din}, 32'd1);
    end

    // Asynchronous reset at slot 20 with a pair pending.
    wait_slot(5'd20, "rst_slot20");
    sample_left = 16'hBEEF; sample_right = 16'h1234; sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
    check("rst_pre_pending", {31'd0, sample_ready}, 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_pins", {28'd0, i2s_bck, i2s_lrck, i2s_din, frame_strobe}, 32'd0);
    check("rst_async_ready", {31'd0, sample_ready}, 32'd1);
    check("rst_async_underrun", {24'd0, underrun_count}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (!m_fe && c < 50);
    if (!m_fe) timeout_fail("rst_first_fe");
    else begin
      check("rst_first_fe_strobe", {31'd0, frame_strobe}, 32'd1);
      check("rst_first_fe_lrck", {31'd0, i2s_lrck}, 32'd0);
    end
    repeat (200) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
